step_decoder: RTL and testbench
===============================

STEP_DECODER -- requirements
Module: step_decoder

Interface
REQ-001 The block SHALL provide parameter SEL_W, default 3, giving the select/index width in bits (legal range 1..6).
REQ-002 The block SHALL provide derived parameter OUT_W, default 2**SEL_W, giving the one-hot output width; it SHALL NOT be overridden.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have the following ports, listed as name, direction, width and meaning:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  output enable; 0 forces an all-zero output
- mode  input  1  0 = DIRECT (decode sel), 1 = STEP (internal sequencer)
- sel  input  SEL_W  index to decode in DIRECT mode
- last  input  SEL_W  final index of the STEP sequence (inclusive)
- restart  input  1  forces the index to 0
- out  output  OUT_W  registered one-hot of idx, or all-zero
- idx  output  SEL_W  registered current index
- wrap  output  1  one-cycle pulse when STEP wraps last->0

Function
REQ-005 All outputs SHALL be registered, with a latency of exactly 1 cycle from the sampled inputs to out, idx and wrap.
REQ-006 On each edge, next idx SHALL be chosen by priority, highest first: restart -> 0; en=0 -> hold; mode=DIRECT -> sel; mode=STEP -> step rule.
REQ-007 STEP rule: if idx >= last, next idx SHALL be 0; otherwise next idx SHALL be idx+1, using SEL_W-bit arithmetic with no carry out.
REQ-008 wrap SHALL be 1 for exactly one cycle after an edge where en=1, mode=STEP, restart=0 and idx >= last; otherwise wrap SHALL be 0.
REQ-009 When next en sample is 1, out SHALL equal one-hot(next idx), with bit k set iff next idx == k; when the en sample is 0, out SHALL be all-zero.
REQ-010 restart SHALL clear idx even when en=0; out SHALL stay all-zero in that case and wrap SHALL be 0.
REQ-011 With last=0 in STEP mode, idx SHALL stay 0 and wrap SHALL pulse every enabled cycle.
REQ-012 A mode switch DIRECT->STEP SHALL continue the sequence from the current idx; if idx > last, the next step SHALL be 0 with wrap=1.
REQ-013 A mode switch STEP->DIRECT SHALL load sel on the same edge and SHALL NOT assert wrap.
REQ-014 A change of last mid-sequence SHALL take effect on the next edge, with no latching of last.
REQ-015 out SHALL be either all-zero or exactly one-hot on every cycle, including immediately after reset.

Reset
REQ-016 When rst_n=0 at an edge: idx=0, out=all-zero, wrap=0, overriding every other input including restart.
REQ-017 Reset mid-sequence SHALL discard the sequence position; the first enabled STEP edge after release SHALL produce idx=1.

Structure
REQ-018 The shared package SHALL hold the mode constants MODE_DIRECT=0 and MODE_STEP=1 and the default SEL_W.
REQ-019 One combinational sub-module, onehot_dec (parameter SEL_W; in a, en; out OUT_W), SHALL perform the decode; step_decoder SHALL feed it the next idx and register its output.
REQ-020 No other sub-modules and no latches SHALL be used; all sequential logic SHALL be in step_decoder.

Verification
REQ-021 Reset/enable: rst_n=0 for 2 cycles, then en=0 -> out=00000000, idx=0, wrap=0; then en=1, DIRECT, sel=5 -> one cycle later out=00100000, idx=5.
REQ-022 DIRECT sweep: SEL_W=3, sel=0..7 on consecutive cycles -> out=00000001..10000000 each lagging by 1 cycle, wrap never set.
REQ-023 STEP wrap: last=3, STEP, en=1 from idx=0 -> idx 1,2,3,0,1; wrap=1 only on the cycle idx returns to 0; out follows one-hot.
REQ-024 Boundaries: last=0 -> wrap every cycle, out=00000001; DIRECT sel=6 then STEP with last=3 -> idx=0, wrap=1.
REQ-025 Priority: restart=1 with en=0 at idx=5 -> idx=0, out=0; rst_n=0 together with restart at idx=2 -> reset values; after release, STEP gives idx=1.
REQ-026 Parameter sweep: SEL_W=1 and SEL_W=5 rerun REQ-023 with last=OUT_W-1 -> full-range wrap, and the one-hot invariant of REQ-015 holds on every cycle.

Source files
------------

// File: rtl/step_decoder_pkg.sv
// Shared definitions for the step decoder.
//   mode_e          : DIRECT (decode sel) or STEP (internal sequencer)
//   DEFAULT_SEL_W   : default index width in bits
package step_decoder_pkg;

  localparam int DEFAULT_SEL_W = 3;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_STEP   = 1'b1
  } mode_e;

endpackage : step_decoder_pkg

// File: rtl/step_decoder_onehot_dec.sv
// Combinational one-hot decoder.
//   a   : index to decode
//   en  : 0 forces an all-zero output
//   out : bit k set iff en and a == k
module onehot_dec #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] a,
  input  logic             en,
  output logic [OUT_W-1:0] out
);

  always_comb begin
    // NOTE: a default assignment ahead of any conditional write keeps this block free of inferred latches.
    out = '0;
    if (en) begin
      out[a] = 1'b1;
    end
  end

endmodule : onehot_dec

// File: rtl/step_decoder.sv
// Index sequencer with registered one-hot decode.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   en         : output enable; 0 holds idx and forces out to zero
//   mode       : DIRECT loads sel, STEP advances 0..last and wraps
//   sel, last  : DIRECT index / final STEP index (inclusive)
//   restart    : forces idx to 0, even when disabled
//   out        : registered one-hot of idx, or all-zero
//   idx        : registered current index
//   wrap       : one-cycle pulse when STEP returns to 0
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter  int SEL_W = DEFAULT_SEL_W,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] last,
  input  logic             restart,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  mode_e            mode_s;
  logic             at_end;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  assign mode_s = mode_e'(mode);

  // ">=" rather than "==" so an index loaded above last in DIRECT mode
  // still returns to 0 on the first STEP edge instead of running on.
  assign at_end = (idx_q >= last);

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (restart) begin
      idx_d = '0;
    end else if (en) begin
      if (mode_s == MODE_DIRECT) begin
        idx_d = sel;
      end else begin
        idx_d  = at_end ? '0 : idx_q + SEL_W'(1);
        wrap_d = at_end;
      end
    end
  end

  // Decode the next index so out lines up with idx after the same edge.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .a   (idx_d),
    .en  (en),
    .out (out_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      idx_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule : step_decoder

// File: tb/tb_step_decoder.sv
// Directed bench for step_decoder at SEL_W = 3, 1 and 5.
module tb_step_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, mode, restart;

  logic [2:0]  sel3, last3, idx3;
  logic [7:0]  out3;
  logic        wrap3;
  logic [0:0]  sel1, last1, idx1;
  logic [1:0]  out1;
  logic        wrap1;
  logic [4:0]  sel5, last5, idx5;
  logic [31:0] out5;
  logic        wrap5;

  step_decoder #(.SEL_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel3), .last(last3),
    .restart(restart), .out(out3), .idx(idx3), .wrap(wrap3)
  );
  step_decoder #(.SEL_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel1), .last(last1),
    .restart(restart), .out(out1), .idx(idx1), .wrap(wrap1)
  );
  step_decoder #(.SEL_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel5), .last(last5),
    .restart(restart), .out(out5), .idx(idx5), .wrap(wrap5)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then sample away from it; out must be zero or one-hot.
  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot3", 32'($onehot0(out3)), 32'd1);
    check("onehot1", 32'($onehot0(out1)), 32'd1);
    check("onehot5", 32'($onehot0(out5)), 32'd1);
  endtask

  task automatic expect3(input string tag, input logic [7:0] o, input logic [2:0] i, input logic w);
    check({tag, ".out"},  32'(out3),  32'(o));
    check({tag, ".idx"},  32'(idx3),  32'(i));
    check({tag, ".wrap"}, 32'(wrap3), 32'(w));
  endtask

  localparam logic [2:0] STEP_IDX  [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
  localparam logic       STEP_WRAP [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; restart = 1'b0;
    sel3 = '0; last3 = '0; sel1 = '0; last1 = '0; sel5 = '0; last5 = '0;

    // Reset, then disabled, then a single DIRECT decode.
    tick(); tick();
    expect3("reset", 8'b00000000, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect3("en0", 8'b00000000, 3'd0, 1'b0);
    en = 1'b1; sel3 = 3'd5;
    tick();
    expect3("direct5", 8'b00100000, 3'd5, 1'b0);

    // restart beats en=0.
    en = 1'b0; restart = 1'b1;
    tick();
    expect3("restart_en0", 8'b00000000, 3'd0, 1'b0);
    restart = 1'b0; en = 1'b1;

    // DIRECT sweep.
    for (int i = 0; i < 8; i++) begin
      sel3 = 3'(i);
      tick();
      expect3($sformatf("sweep%0d", i), 8'(1 << i), 3'(i), 1'b0);
    end

    // STEP 0..3 with wrap.
    restart = 1'b1;
    tick();
    expect3("restart_en1", 8'b00000001, 3'd0, 1'b0);
    restart = 1'b0; mode = 1'b1; last3 = 3'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect3($sformatf("step%0d", i), 8'(1 << STEP_IDX[i]), STEP_IDX[i], STEP_WRAP[i]);
    end

    // last = 0: pinned at 0, wrap every cycle.
    last3 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect3($sformatf("last0_%0d", i), 8'b00000001, 3'd0, 1'b1);
    end

    // DIRECT loads 6, STEP with last=3 returns to 0 with wrap.
    mode = 1'b0; sel3 = 3'd6;
    tick();
    expect3("direct6", 8'b01000000, 3'd6, 1'b0);
    mode = 1'b1; last3 = 3'd3;
    tick();
    expect3("over_last", 8'b00000001, 3'd0, 1'b1);

    // STEP -> DIRECT loads sel with no wrap even though idx >= last.
    tick();
    expect3("step_to1", 8'b00000010, 3'd1, 1'b0);
    mode = 1'b0; sel3 = 3'd4; last3 = 3'd0;
    tick();
    expect3("to_direct", 8'b00010000, 3'd4, 1'b0);

    // last changed mid-sequence acts on the next edge.
    mode = 1'b1; last3 = 3'd7;
    tick();
    expect3("last7", 8'b00100000, 3'd5, 1'b0);
    last3 = 3'd2;
    tick();
    expect3("last2", 8'b00000001, 3'd0, 1'b1);

    // Reset overrides restart; first STEP after release gives 1.
    mode = 1'b0; sel3 = 3'd2;
    tick();
    expect3("direct2", 8'b00000100, 3'd2, 1'b0);
    rst_n = 1'b0; restart = 1'b1; mode = 1'b1; last3 = 3'd3;
    tick();
    expect3("rst_restart", 8'b00000000, 3'd0, 1'b0);
    rst_n = 1'b1; restart = 1'b0;
    tick();
    expect3("post_rst", 8'b00000010, 3'd1, 1'b0);

    // en = 0 holds idx and blanks out.
    en = 1'b0;
    tick();
    expect3("hold", 8'b00000000, 3'd1, 1'b0);

    // Full-range STEP on every width.
    en = 1'b1; restart = 1'b1;
    tick();
    check("sw_start1", 32'(idx1), 32'd0);
    check("sw_start5", 32'(out5), 32'd1);
    restart = 1'b0; mode = 1'b1; last3 = 3'd7; last1 = 1'b1; last5 = 5'd31;
    for (int k = 0; k < 34; k++) begin
      int e3, e1, e5;
      e3 = (k + 1) % 8;
      e1 = (k + 1) % 2;
      e5 = (k + 1) % 32;
      tick();
      expect3($sformatf("full3_%0d", k), 8'(1 << e3), 3'(e3), e3 == 0);
      check($sformatf("full1_%0d.idx", k),  32'(idx1),  32'(e1));
      check($sformatf("full1_%0d.out", k),  32'(out1),  32'(1) << e1);
      check($sformatf("full1_%0d.wrap", k), 32'(wrap1), 32'(e1 == 0));
      check($sformatf("full5_%0d.idx", k),  32'(idx5),  32'(e5));
      check($sformatf("full5_%0d.out", k),  out5,       32'(1) << e5);
      check($sformatf("full5_%0d.wrap", k), 32'(wrap5), 32'(e5 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_step_decoder
